// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared counter encodings and constants for the branch predictor
package branch_predictor_pkg;

    // 2-bit saturating counter states: strongly/weakly not-taken, weakly/strongly taken
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_state_t;

    localparam logic [1:0]  CNT_INIT_DEF  = 2'b01;
    localparam logic [1:0]  ALLOC_CNT_DEF = 2'b10;
    localparam logic [31:0] PC_INC        = 32'd4;

    // Event counter increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup and decode resolution signals of the branch predictor
interface branch_predictor_if;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        id_branch;
    logic        id_stall;
    logic [31:0] id_pc;
    logic        id_pred_taken;
    logic [31:0] id_pred_target;
    logic        comp_true;
    logic [31:0] id_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        flush_ifid;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    modport master (
        output if_pc, id_branch, id_stall, id_pc, id_pred_taken, id_pred_target,
               comp_true, id_target,
        input  pred_taken, pred_target, mispredict, redirect_pc, flush_ifid,
               stat_branches, stat_mispredicts
    );

    modport slave (
        input  if_pc, id_branch, id_stall, id_pc, id_pred_taken, id_pred_target,
               comp_true, id_target,
        output pred_taken, pred_target, mispredict, redirect_pc, flush_ifid,
               stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// rtl/branch_predictor_sat_counter2.sv - 2-bit saturating up/down step for the direction counters
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       up,
    output logic [1:0] cnt_next
);

    // Step towards ST on taken, towards SNT on not-taken, holding at either end
    always_comb begin
        cnt_next = cnt;
        if (up) begin
            if (cnt != ST) cnt_next = cnt + 2'd1;
        end else begin
            if (cnt != SNT) cnt_next = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters and single-cycle branch resolution
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int         IDX_BITS  = 6,
    parameter logic [1:0] CNT_INIT  = CNT_INIT_DEF,
    parameter logic [1:0] ALLOC_CNT = ALLOC_CNT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    branch_predictor_if.slave   bp
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 30 - IDX_BITS;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    logic [1:0]        cnt_q    [ENTRIES];

    logic [31:0] stat_br_q;
    logic [31:0] stat_mp_q;

    logic [IDX_BITS-1:0] if_idx;
    logic [TAG_W-1:0]    if_tag;
    logic                if_hit;
    logic [IDX_BITS-1:0] id_idx;
    logic [TAG_W-1:0]    id_tag;
    logic                id_hit;
    logic                resolve;
    logic                target_wrong;
    logic [1:0]          cnt_stepped;
    logic                unused_pc_bits;

    assign if_idx = bp.if_pc[IDX_BITS+1:2];
    assign if_tag = bp.if_pc[31:IDX_BITS+2];
    assign id_idx = bp.id_pc[IDX_BITS+1:2];
    assign id_tag = bp.id_pc[31:IDX_BITS+2];

    // Word alignment bits carry no information for indexing or tagging
    assign unused_pc_bits = ^{bp.if_pc[1:0], bp.id_pc[1:0]};

    // Fetch-side lookup reads the table as it stands; a same-cycle update is not forwarded
    assign if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign bp.pred_taken  = if_hit && cnt_q[if_idx][1];
    assign bp.pred_target = bp.pred_taken ? target_q[if_idx] : 32'd0;

    // A stalled branch may be looking at stale operands, so it resolves only once released
    assign resolve      = bp.id_branch && !bp.id_stall;
    assign target_wrong = bp.id_pred_taken && bp.comp_true && (bp.id_pred_target != bp.id_target);
    assign bp.mispredict  = resolve && ((bp.id_pred_taken != bp.comp_true) || target_wrong);
    assign bp.flush_ifid  = bp.mispredict;
    assign bp.redirect_pc = !resolve     ? 32'd0 :
                            bp.comp_true ? bp.id_target : bp.id_pc + PC_INC;

    assign id_hit = valid_q[id_idx] && (tag_q[id_idx] == id_tag);

    sat_counter2 u_cnt_step (
        .cnt      (cnt_q[id_idx]),
        .up       (bp.comp_true),
        .cnt_next (cnt_stepped)
    );

    // Train the entry of the resolving branch: step on hit, allocate only on a taken miss
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                cnt_q[i]    <= CNT_INIT;
            end
        end else if (resolve) begin
            if (id_hit) begin
                cnt_q[id_idx] <= cnt_stepped;
                if (bp.comp_true) target_q[id_idx] <= bp.id_target;
            end else if (bp.comp_true) begin
                valid_q[id_idx]  <= 1'b1;
                tag_q[id_idx]    <= id_tag;
                target_q[id_idx] <= bp.id_target;
                cnt_q[id_idx]    <= ALLOC_CNT;
            end
        end
    end

    // Resolved-branch and mispredict counters, saturating rather than wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q <= 32'd0;
            stat_mp_q <= 32'd0;
        end else begin
            stat_br_q <= sat_inc32(stat_br_q, resolve);
            stat_mp_q <= sat_inc32(stat_mp_q, bp.mispredict);
        end
    end

    assign bp.stat_branches    = stat_br_q;
    assign bp.stat_mispredicts = stat_mp_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor against a table model
module tb_branch_predictor;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    branch_predictor_if bp();

    branch_predictor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp)
    );

    // Reference table: one slot per index, counter kept as a plain integer 0..3
    bit          m_valid [64];
    longint      m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_cnt   [64];
    longint      m_br;
    longint      m_mp;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h, expected %h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_tgt[i]   = 32'd0;
            m_cnt[i]   = 1;
        end
        m_br = 0;
        m_mp = 0;
    endtask

    function automatic int slot(input logic [31:0] pc);
        return int'((longint'(pc) / 4) % 64);
    endfunction

    function automatic longint tag_of(input logic [31:0] pc);
        return longint'(pc) / 256;
    endfunction

    task automatic model_lookup(input logic [31:0] pc, output bit taken, output logic [31:0] tgt);
        int s;
        s = slot(pc);
        taken = m_valid[s] && (m_tag[s] == tag_of(pc)) && (m_cnt[s] >= 2);
        tgt   = m_tgt[s];
    endtask

    task automatic step(input logic [31:0] ipc, input bit br, input bit st,
                        input logic [31:0] ipc_id, input bit pt, input logic [31:0] ptg,
                        input bit ct, input logic [31:0] tg);
        bit          et, res, emis, hit;
        logic [31:0] etg, eredir;
        int          s;
        bp.if_pc = ipc;          bp.id_branch = br;       bp.id_stall = st;
        bp.id_pc = ipc_id;       bp.id_pred_taken = pt;   bp.id_pred_target = ptg;
        bp.comp_true = ct;       bp.id_target = tg;
        #1;
        model_lookup(ipc, et, etg);
        res    = br && !st;
        emis   = res && ((pt != ct) || (pt && ct && ptg != tg));
        eredir = !res ? 32'd0 : (ct ? tg : ipc_id + 32'd4);
        check("pred_taken", {31'd0, bp.pred_taken}, {31'd0, et});
        if (et) check("pred_target", bp.pred_target, etg);
        check("mispredict", {31'd0, bp.mispredict}, {31'd0, emis});
        check("flush_ifid", {31'd0, bp.flush_ifid}, {31'd0, emis});
        check("redirect_pc", bp.redirect_pc, eredir);
        check("stat_branches", bp.stat_branches, 32'(m_br));
        check("stat_mispredicts", bp.stat_mispredicts, 32'(m_mp));
        @(posedge clk);
        if (res) begin
            s   = slot(ipc_id);
            hit = m_valid[s] && (m_tag[s] == tag_of(ipc_id));
            if (hit) begin
                m_cnt[s] = ct ? ((m_cnt[s] < 3) ? m_cnt[s] + 1 : 3)
                              : ((m_cnt[s] > 0) ? m_cnt[s] - 1 : 0);
                if (ct) m_tgt[s] = tg;
            end else if (ct) begin
                m_valid[s] = 1;
                m_tag[s]   = tag_of(ipc_id);
                m_tgt[s]   = tg;
                m_cnt[s]   = 2;
            end
            if (m_br < 64'hFFFF_FFFF) m_br++;
            if (emis && m_mp < 64'hFFFF_FFFF) m_mp++;
        end
        @(negedge clk);
    endtask

    // Resolve a branch whose IF/ID prediction is what the table gave at fetch time
    task automatic resolve_pred(input logic [31:0] ipc, input logic [31:0] ipc_id,
                                input bit ct, input logic [31:0] tg);
        bit          pt;
        logic [31:0] ptg;
        model_lookup(ipc_id, pt, ptg);
        step(ipc, 1'b1, 1'b0, ipc_id, pt, ptg, ct, tg);
    endtask

    task automatic lookup_only(input logic [31:0] ipc);
        step(ipc, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic drive_idle(input logic [31:0] ipc);
        bp.if_pc = ipc;         bp.id_branch = 1'b0;   bp.id_stall = 1'b0;
        bp.id_pc = 32'd0;       bp.id_pred_taken = 1'b0; bp.id_pred_target = 32'd0;
        bp.comp_true = 1'b0;    bp.id_target = 32'd0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pred_taken"}, {31'd0, bp.pred_taken}, 32'd0);
        check({tag, "_pred_target"}, bp.pred_target, 32'd0);
        check({tag, "_mispredict"}, {31'd0, bp.mispredict}, 32'd0);
        check({tag, "_flush"}, {31'd0, bp.flush_ifid}, 32'd0);
        check({tag, "_redirect"}, bp.redirect_pc, 32'd0);
        check({tag, "_stat_br"}, bp.stat_branches, 32'd0);
        check({tag, "_stat_mp"}, bp.stat_mispredicts, 32'd0);
    endtask

    initial begin
        logic [31:0] pc, tg;
        bit          pt;
        logic [31:0] ptg;

        // Reset state
        rst_n = 1'b0;
        drive_idle(32'h0040_0010);
        model_reset();
        #2;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Taken miss allocates and mispredicts; next lookup predicts taken
        step(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0010, 1'b0, 32'd0, 1'b1, 32'h0040_0040);
        lookup_only(32'h0040_0010);

        // Two not-taken: 10 -> 01 -> 00, first one redirects to pc+4
        resolve_pred(32'h0040_0000, 32'h0040_0010, 1'b0, 32'h0040_0040);
        resolve_pred(32'h0040_0000, 32'h0040_0010, 1'b0, 32'h0040_0040);
        lookup_only(32'h0040_0010);

        // Four taken from 00: only the first two mispredict, counter saturates at 11
        repeat (4) resolve_pred(32'h0040_0000, 32'h0040_0010, 1'b1, 32'h0040_0040);
        check("stat_branches_dir", bp.stat_branches, 32'd7);
        check("stat_mispredicts_dir", bp.stat_mispredicts, 32'd4);

        // Stalled branch for two cycles: nothing resolves, then release resolves once
        step(32'h0040_0000, 1'b1, 1'b1, 32'h0040_0010, 1'b0, 32'd0, 1'b1, 32'h0040_0080);
        step(32'h0040_0000, 1'b1, 1'b1, 32'h0040_0010, 1'b0, 32'd0, 1'b0, 32'h0040_0080);
        resolve_pred(32'h0040_0000, 32'h0040_0010, 1'b0, 32'h0040_0040);
        check("stat_branches_stall", bp.stat_branches, 32'd8);

        // Aliasing overwrite while IF reads the same index: IF sees the old entry
        resolve_pred(32'h0040_0010, 32'h0041_0010, 1'b1, 32'h0041_0100);
        lookup_only(32'h0040_0010);
        lookup_only(32'h0041_0010);

        // Not-taken fall-through wraps at the top of the address space
        step(32'h0040_0000, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h1234_5678, 1'b0, 32'h0000_0100);

        // Randomized traffic over a small PC pool so entries hit, alias and saturate
        for (int n = 0; n < 400; n++) begin
            pc = 32'h0040_0000 + ($urandom_range(0, 7) << 2) + ($urandom_range(0, 1) << 16);
            tg = 32'h0040_1000 + ($urandom_range(0, 3) << 4);
            model_lookup(pc, pt, ptg);
            if ($urandom_range(0, 4) == 0) begin
                pt  = 1'($urandom);
                ptg = tg;
            end
            step(32'h0040_0000 + ($urandom_range(0, 15) << 2) + ($urandom_range(0, 1) << 16),
                 1'($urandom_range(0, 3) != 0), $urandom_range(0, 4) == 0,
                 pc, pt, ptg, 1'($urandom), tg);
        end

        // Asynchronous reset in the middle of a resolving cycle
        resolve_pred(32'h0040_0000, 32'h0040_0020, 1'b1, 32'h0040_0200);
        bp.if_pc = 32'h0040_0020;
        bp.id_branch = 1'b1;
        bp.id_pc = 32'h0040_0020;
        bp.comp_true = 1'b1;
        bp.id_target = 32'h0040_0300;
        #2;
        rst_n = 1'b0;
        bp.id_branch = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        lookup_only(32'h0040_0020);
        lookup_only(32'h0040_0010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor and resolution unit for the 5-stage pipeline.
- IF side: looks up the fetch PC in a direct-mapped branch target buffer (BTB), which holds a 2-bit saturating counter per entry, and supplies the predicted next PC.
- ID side: consumes the branch comparator's taken/not-taken result and the computed branch target. It detects mispredictions, issues the redirect PC and the IF/ID flush, and updates the table.

Parameters:
- IDX_BITS, 6, log2 of BTB entries (64 entries); index = pc[IDX_BITS+1:2].
- CNT_INIT, 2'b01, counter value written on reset (weakly not-taken).
- ALLOC_CNT, 2'b10, counter value written on allocation (weakly taken).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- if_pc  in  32  PC of the instruction in IF.
- pred_taken  out  1  prediction for if_pc (valid & tag hit & cnt[1]).
- pred_target  out  32  stored target for if_pc; meaningful only when pred_taken=1.
- id_branch  in  1  ID holds a conditional branch (beq/bne/blez/bgtz/bltz).
- id_stall  in  1  ID held this cycle (load-use hazard on branch operands).
- id_pc  in  32  PC of the branch in ID.
- id_pred_taken  in  1  pred_taken carried through the IF/ID register.
- id_pred_target  in  32  pred_target carried through the IF/ID register.
- comp_true  in  1  comparator result for the branch in ID.
- id_target  in  32  computed branch target (id_pc+4+(sext(imm)<<2)).
- mispredict  out  1  redirect required this cycle.
- redirect_pc  out  32  corrected fetch PC.
- flush_ifid  out  1  squash the IF/ID register on the next edge.
- stat_branches  out  32  resolved branch count.
- stat_mispredicts  out  32  mispredict count.

Behaviour:
- Tag = pc[31:IDX_BITS+2]. Each entry holds {valid, tag, target[31:0], cnt[1:0]}.
- Lookup is combinational from current table contents. There is no bypass, so an update written at edge N is first visible to a lookup after edge N.
- resolve = id_branch & ~id_stall. While stalled, the operands may be stale, so no outputs assert and the table is not updated.
- mispredict = resolve & ((id_pred_taken != comp_true) | (id_pred_taken & comp_true & id_pred_target != id_target)). It is combinational, same cycle as comp_true.
- redirect_pc = comp_true ? id_target : id_pc + 4 (mod 2^32, wraps silently). It is driven whenever resolve=1; otherwise 0.
- flush_ifid = mispredict.
- Update at posedge when resolve=1:
  - Hit: cnt saturating +1 if comp_true (ceiling 2'b11), -1 otherwise (floor 2'b00). If comp_true, target <= id_target.
  - Miss and comp_true: allocate or overwrite the entry: valid=1, tag, target=id_target, cnt=ALLOC_CNT.
  - Miss and not taken: no change.
- Stats: stat_branches += resolve and stat_mispredicts += mispredict, each saturating at 32'hFFFF_FFFF.
- Same-index conflict: an IF lookup and an ID update to the same index in one cycle returns the pre-update entry.
- Async reset, at any time including mid-update: all valid=0, cnt=CNT_INIT, target=0, stats=0.
- During reset, mispredict, flush_ifid, redirect_pc, pred_taken and pred_target are all 0; these outputs are combinational and gated by the cleared valid bits and by the inputs.
- Single-cycle resolution; no FSM beyond the per-entry counter state machine: SNT(00) <-> WNT(01) <-> WT(10) <-> ST(11).

Decomposition:
- Shared pipeline package holds the counter encodings (SNT/WNT/WT/ST), ALLOC_CNT and CNT_INIT defaults, and a PC_INC=4 constant.
- One sub-module, sat_counter2: 2-bit saturating up/down step function used by the update path.
- The BTB arrays stay in branch_predictor as register arrays so all entries can be cleared in one reset.

Test Plan:
- Reset, then if_pc=0x0040_0010 -> pred_taken=0, pred_target=0, stats=0.
- Branch at id_pc=0x0040_0010, comp_true=1, id_target=0x0040_0040, id_pred_taken=0 -> mispredict=1, flush_ifid=1, redirect_pc=0x0040_0040. Next cycle if_pc=0x0040_0010 -> pred_taken=1, pred_target=0x0040_0040.
- Same branch not taken twice after allocation -> cnt 10->01->00. First resolve mispredicts with redirect_pc=0x0040_0014; the later lookup shows pred_taken=0.
- Taken 3 more times from 00 -> cnt 01, 10, 11, then a 4th taken stays 11. stat_branches counts every resolve; stat_mispredicts counts only the prediction flips.
- id_branch=1, id_stall=1 for 2 cycles with comp_true toggling -> mispredict=0, no table or stat change. The release cycle resolves exactly once.
- Aliasing: id_pc=0x0040_0010 allocated, then 0x0041_0010 taken to 0x0041_0100 -> entry overwritten. A lookup of 0x0040_0010 misses. A simultaneous IF lookup on the update cycle returns the old entry. Assert rst_n=0 mid-sequence -> all outputs 0 immediately.
